// File: rtl/sdram_arbiter_if.sv
// Client-port and Avalon-MM master bundle for the two-port SDRAM arbiter.
// master = arbiter side, slave = clients plus SDRAM controller side.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_done;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_done;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  logic              busy;

  modport master (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_rdata, p0_done,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_rdata, p1_done,
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output busy
  );

  modport slave (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_rdata, p0_done,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_rdata, p1_done,
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  busy
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port arbiter onto one Avalon-MM SDRAM master, one access in flight.
// Port 0 has priority; port 1 is forced through after STARVE_MAX losses.
module sdram_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  sdram_arbiter_if.master      bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              p0_done_q;
  logic              p1_done_q;
  logic [DATA_W-1:0] p0_rdata_q;
  logic [DATA_W-1:0] p1_rdata_q;

  logic              gnt_vld;
  logic              gnt_id;
  logic              fin;
  logic              cap;
  logic              any_done;

  assign any_done = p0_done_q | p1_done_q;

  // State register; reset lands in IDLE at once, dropping any access.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration, issue and read-return sequencing.
  always_comb begin
    state_d = state_q;
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    fin     = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The finishing port still holds req while done is high.
        if (!any_done) begin
          if (bus.p0_req && bus.p1_req) begin
            gnt_vld = 1'b1;
            gnt_id  = (cnt_q == CNT_MAX);
          end else if (bus.p0_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
          end else if (bus.p1_req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
          end
          if (gnt_vld) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!bus.avm_waitrequest) begin
          if (we_q) begin
            fin     = 1'b1;
            state_d = IDLE;
          end else if (bus.avm_readdatavalid) begin
            fin     = 1'b1;
            cap     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (bus.avm_readdatavalid) begin
          fin     = 1'b1;
          cap     = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the granted request and track port-1 starvation.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else if (gnt_vld) begin
      owner_q <= gnt_id;
      we_q    <= gnt_id ? bus.p1_we    : bus.p0_we;
      addr_q  <= gnt_id ? bus.p1_addr  : bus.p0_addr;
      wdata_q <= gnt_id ? bus.p1_wdata : bus.p0_wdata;
      if (gnt_id) begin
        cnt_q <= '0;
      end else if (bus.p1_req && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Completion pulse and read data steered to the owning port.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      p0_done_q <= fin && !owner_q;
      p1_done_q <= fin && owner_q;
      if (cap && !owner_q) begin
        p0_rdata_q <= bus.avm_readdata;
      end
      if (cap && owner_q) begin
        p1_rdata_q <= bus.avm_readdata;
      end
    end
  end

  assign bus.avm_read      = (state_q == ISSUE) && !we_q;
  assign bus.avm_write     = (state_q == ISSUE) && we_q;
  assign bus.avm_address   = addr_q;
  assign bus.avm_writedata = wdata_q;
  assign bus.p0_done       = p0_done_q;
  assign bus.p1_done       = p1_done_q;
  assign bus.p0_rdata      = p0_rdata_q;
  assign bus.p1_rdata      = p1_rdata_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised bench for sdram_arbiter against a transaction-level model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_sdram_arbiter;
  localparam int AW   = 25;
  localparam int DW   = 16;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .bus          (bus.master)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // client state
  bit          c_req[2];
  bit          c_we[2];
  logic [AW-1:0] c_addr[2];
  logic [DW-1:0] c_wdata[2];
  bit          c_out[2];
  bit          c_drop[2];
  int          c_mode[2];

  // transaction model
  int          tick_n = 0;
  int          phase = 0;
  int          done_tick = -1;
  int          starve = 0;
  int          g_own = 0;
  bit          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [DW-1:0] exp_rd;
  logic [DW-1:0] last_rd[2];
  logic [DW-1:0] obs_rd[2];
  int          done_at[2];
  bit          first_issue = 0;
  int          grants[$];
  int          n_wr_hi = 0;
  int          n_d0 = 0;
  int          n_d1 = 0;

  // slave model
  logic [DW-1:0] mem[logic [AW-1:0]];
  int          ws_left = 0;
  int          lat_left = 0;
  int          ws_force = -1;
  int          lat_force = -1;
  bit          stray_en = 0;
  bit          stray_once = 0;

  function automatic logic [DW-1:0] memrd(logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  task automatic new_txn(int i, bit we);
    c_req[i]   = 1'b1;
    c_we[i]    = we;
    c_addr[i]  = AW'(i * 16 + $urandom_range(0, 15));
    c_wdata[i] = DW'($urandom);
    c_drop[i]  = (c_mode[i] == 2) && ($urandom_range(0, 3) == 0);
  endtask

  task automatic drive_clients();
    bus.p0_req   = c_req[0];
    bus.p0_we    = c_we[0];
    bus.p0_addr  = c_addr[0];
    bus.p0_wdata = c_wdata[0];
    bus.p1_req   = c_req[1];
    bus.p1_we    = c_we[1];
    bus.p1_addr  = c_addr[1];
    bus.p1_wdata = c_wdata[1];
  endtask

  task automatic reset_model();
    phase = 0;
    done_tick = -1;
    starve = 0;
    first_issue = 0;
    ws_left = 0;
    lat_left = 0;
    for (int i = 0; i < 2; i++) begin
      c_req[i] = 0;
      c_out[i] = 0;
      c_drop[i] = 0;
      c_mode[i] = 0;
      last_rd[i] = '0;
    end
    drive_clients();
  endtask

  task automatic tick();
    bit dn;
    bit rdv;
    bit wreq;
    logic [DW-1:0] rdat;
    int lat;
    int ow;
    @(negedge clk);
    tick_n++;
    dn = (tick_n == done_tick);
    chk("busy", 64'(bus.busy), 64'(phase != 0));
    chk("strobe", 64'({bus.avm_read, bus.avm_write}),
        64'({phase == 1 && !g_we, phase == 1 && g_we}));
    chk("done", 64'({bus.p1_done, bus.p0_done}),
        64'({dn && g_own == 1, dn && g_own == 0}));
    if (bus.avm_write) n_wr_hi++;
    if (bus.p0_done) n_d0++;
    if (bus.p1_done) n_d1++;
    if (phase == 1) begin
      chk("addr", 64'(bus.avm_address), 64'(g_addr));
      if (g_we) chk("wdata", 64'(bus.avm_writedata), 64'(g_wdata));
      if (first_issue) begin
        grants.push_back(int'(bus.avm_address[4]));
        first_issue = 0;
      end
    end
    if (dn) begin
      obs_rd[0] = bus.p0_rdata;
      obs_rd[1] = bus.p1_rdata;
      if (!g_we) chk("rdata", 64'(obs_rd[g_own]), 64'(exp_rd));
      chk("rdata_hold", 64'(obs_rd[1-g_own]), 64'(last_rd[1-g_own]));
      if (!g_we) last_rd[g_own] = exp_rd;
      done_at[g_own] = tick_n;
      c_out[g_own] = 0;
      if (c_mode[g_own] == 1) new_txn(g_own, 1'b1);
      else c_req[g_own] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (c_out[i] && c_drop[i]) c_req[i] = 0;
      if (c_mode[i] == 2 && !c_req[i] && !c_out[i] && $urandom_range(0, 2) == 0)
        new_txn(i, 1'($urandom_range(0, 1)));
    end
    drive_clients();
    // slave response
    rdv  = 0;
    rdat = DW'($urandom);
    wreq = 1'($urandom);
    if (phase == 1) begin
      if (ws_left > 0) begin
        wreq = 1;
        ws_left--;
      end else begin
        wreq = 0;
        if (g_we) begin
          mem[g_addr] = g_wdata;
        end else begin
          lat = (lat_force >= 0) ? lat_force : $urandom_range(0, 3);
          if (lat == 0) begin
            rdv = 1;
            rdat = memrd(g_addr);
          end else begin
            lat_left = lat;
          end
        end
      end
    end else if (phase == 2) begin
      lat_left--;
      if (lat_left == 0) begin
        rdv = 1;
        rdat = memrd(g_addr);
      end
    end else if (stray_once || (stray_en && $urandom_range(0, 3) == 0)) begin
      rdv = 1;
      stray_once = 0;
    end
    bus.avm_waitrequest   = wreq;
    bus.avm_readdata      = rdat;
    bus.avm_readdatavalid = rdv;
    // expected state for the next cycle
    case (phase)
      0: begin
        if (!dn && (c_req[0] || c_req[1])) begin
          if (c_req[0] && c_req[1]) ow = (starve == SMAX) ? 1 : 0;
          else ow = c_req[1] ? 1 : 0;
          if (ow == 1) starve = 0;
          else if (c_req[1] && starve < SMAX) starve++;
          g_own = ow;
          g_we = c_we[ow];
          g_addr = c_addr[ow];
          g_wdata = c_wdata[ow];
          c_out[ow] = 1;
          phase = 1;
          first_issue = 1;
          ws_left = (ws_force >= 0) ? ws_force : $urandom_range(0, 2);
        end
      end
      1: begin
        if (!wreq) begin
          if (g_we || rdv) begin
            exp_rd = rdat;
            done_tick = tick_n + 1;
            phase = 0;
          end else begin
            phase = 2;
          end
        end
      end
      default: begin
        if (rdv) begin
          exp_rd = rdat;
          done_tick = tick_n + 1;
          phase = 0;
        end
      end
    endcase
  endtask

  task automatic settle();
    int n = 0;
    while ((phase != 0 || c_req[0] || c_req[1] || c_out[0] || c_out[1] ||
            tick_n < done_tick) && n < 80) begin
      tick();
      n++;
    end
    chk("settle_timeout", 64'(n < 80), 64'd1);
    tick();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_strobe"}, 64'({bus.avm_read, bus.avm_write}), 64'd0);
    chk({tag, "_done"}, 64'({bus.p1_done, bus.p0_done}), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_addr"}, 64'(bus.avm_address), 64'd0);
    chk({tag, "_wdata"}, 64'(bus.avm_writedata), 64'd0);
    chk({tag, "_rd0"}, 64'(bus.p0_rdata), 64'd0);
    chk({tag, "_rd1"}, 64'(bus.p1_rdata), 64'd0);
  endtask

  initial begin
    int t0;
    reset_model();
    bus.avm_waitrequest = 0;
    bus.avm_readdata = '0;
    bus.avm_readdatavalid = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;

    // write with two wait states
    c_req[0] = 1; c_we[0] = 1; c_addr[0] = 25'h0000100; c_wdata[0] = 16'hBEEF;
    ws_force = 2;
    n_wr_hi = 0; n_d0 = 0; n_d1 = 0;
    t0 = tick_n + 1;
    settle();
    chk("s043_wr_cycles", 64'(n_wr_hi), 64'd3);
    chk("s043_done_cnt", 64'(n_d0), 64'd1);
    chk("s043_latency", 64'(done_at[0] - t0), 64'd4);
    chk("s043_mem", 64'(memrd(25'h0000100)), 64'hBEEF);

    // read with data two cycles after accept
    mem[25'h1FFFFFE] = 16'h1234;
    ws_force = 0; lat_force = 2;
    c_req[1] = 1; c_we[1] = 0; c_addr[1] = 25'h1FFFFFE;
    n_d0 = 0; n_d1 = 0;
    t0 = tick_n + 1;
    settle();
    chk("s044_rdata", 64'(obs_rd[1]), 64'h1234);
    chk("s044_latency", 64'(done_at[1] - t0), 64'd4);
    chk("s044_p0_done", 64'(n_d0), 64'd0);
    chk("s044_p1_done", 64'(n_d1), 64'd1);
    ws_force = -1; lat_force = -1;

    // simultaneous one-shot writes
    grants.delete();
    c_req[0] = 1; c_we[0] = 1; c_addr[0] = 25'h20; c_wdata[0] = 16'h1111;
    c_req[1] = 1; c_we[1] = 1; c_addr[1] = 25'h30; c_wdata[1] = 16'h2222;
    settle();
    chk("s047_ngrant", 64'(grants.size()), 64'd2);
    if (grants.size() == 2) begin
      chk("s047_first", 64'(grants[0]), 64'd0);
      chk("s047_second", 64'(grants[1]), 64'd1);
    end

    // both ports hammering writes
    grants.delete();
    c_mode[0] = 1; c_mode[1] = 1;
    new_txn(0, 1'b1);
    new_txn(1, 1'b1);
    for (int n = 0; n < 200 && grants.size() < 15; n++) tick();
    chk("s045_ngrant", 64'(grants.size() >= 15), 64'd1);
    for (int k = 0; k < 15 && k < grants.size(); k++)
      chk("s045_order", 64'(grants[k]), 64'((k % 5) == 4));
    c_mode[0] = 0; c_mode[1] = 0;
    settle();

    // requester drops req right after grant
    c_req[0] = 1; c_we[0] = 0; c_addr[0] = 25'h5; c_drop[0] = 1;
    n_d0 = 0;
    settle();
    chk("s048_done_cnt", 64'(n_d0), 64'd1);
    chk("s048_req_dropped", 64'(bus.p0_req), 64'd0);
    c_drop[0] = 0;

    // random traffic
    c_mode[0] = 2; c_mode[1] = 2;
    stray_en = 1;
    repeat (2000) tick();
    c_mode[0] = 0; c_mode[1] = 0;
    stray_en = 0;
    settle();

    // reset while waiting on read data
    lat_force = 6;
    c_req[1] = 1; c_we[1] = 0; c_addr[1] = 25'h40;
    for (int n = 0; n < 20 && phase != 2; n++) tick();
    chk("s046_in_wait", 64'(bus.busy), 64'd1);
    #2 rst_n = 0;
    #1 chk_zero("async_rst");
    reset_model();
    lat_force = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    stray_once = 1;
    n_d0 = 0; n_d1 = 0;
    repeat (6) tick();
    chk("s046_no_done", 64'(n_d0 + n_d1), 64'd0);
    chk_zero("s046_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25, SDRAM byte-address width.
REQ-002 Parameter DATA_W, default 16, data width, matching the 16-bit SDRAM DQ.
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive port-0 grants while port 1 is pending.
REQ-004 clk_clk  in  1  single clock (50 MHz); all state is updated on the rising edge.
REQ-005 reset_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 p0_req / p1_req  in  1  port request, held high until that port's done pulse.
REQ-007 p0_we / p1_we  in  1  1 = write, 0 = read; sampled at grant.
REQ-008 p0_addr / p1_addr  in  ADDR_W  access address; sampled at grant.
REQ-009 p0_wdata / p1_wdata  in  DATA_W  write data; sampled at grant.
REQ-010 p0_rdata / p1_rdata  out  DATA_W  read data; valid only while the matching done is high.
REQ-011 p0_done / p1_done  out  1  one-cycle completion pulse.
REQ-012 avm_address  out  ADDR_W  master address to the SDRAM controller.
REQ-013 avm_read / avm_write  out  1  Avalon-MM read and write strobes.
REQ-014 avm_writedata  out  DATA_W  master write data.
REQ-015 avm_waitrequest  in  1  slave stall.
REQ-016 avm_readdata  in  DATA_W  slave read data.
REQ-017 avm_readdatavalid  in  1  slave read-data strobe.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states are IDLE, ISSUE and WAIT_RD, and only one transaction is outstanding at any time.
REQ-020 IDLE with no request: stay in IDLE with all strobes low.
REQ-021 IDLE with one request: grant that port, latch its we, addr and wdata plus the owner ID, then go to ISSUE on the next edge.
REQ-022 IDLE with both requesting: grant port 0, unless starve_cnt equals STARVE_MAX, in which case grant port 1.
REQ-023 starve_cnt increments on each port-0 grant made while p1_req is high.
REQ-024 starve_cnt clears on any port-1 grant and saturates at STARVE_MAX.
REQ-025 In ISSUE, avm_read or avm_write (per the latched we) is asserted with the latched address and data.
REQ-026 The strobe, address and data are held stable while avm_waitrequest is high.
REQ-027 On ISSUE with waitrequest low and a write: pulse the owner's done in the next cycle, deassert the strobe, and return to IDLE.
REQ-028 On ISSUE with waitrequest low and a read: deassert the strobe and go to WAIT_RD.
REQ-029 In WAIT_RD, on avm_readdatavalid: register readdata into the owner's rdata, pulse the owner's done in the next cycle, and return to IDLE.
REQ-030 A readdatavalid arriving in the same cycle as the ISSUE accept is captured, and the FSM goes straight to IDLE with done on the next cycle.
REQ-031 readdatavalid outside a read transaction is ignored.
REQ-032 Latency: a write with no wait states completes in 3 cycles (req high to done).
REQ-033 Latency: a read with readdata valid N cycles after accept completes in N+3 cycles.
REQ-034 There is no grant in the cycle that done is high.
REQ-035 A port whose req stays high after its done is re-arbitrated the next cycle, so back-to-back requests get a 1-cycle gap.
REQ-036 The non-owner's rdata holds its last value, and its done stays low.
REQ-037 Deasserting req after a grant does not abort the transaction; the transaction completes and done still pulses.

Reset
REQ-038 Asserting reset_reset_n low immediately forces IDLE, asynchronously, including mid-transaction.
REQ-039 Reset clears avm_read, avm_write, both done outputs, busy and starve_cnt to 0.
REQ-040 Reset sets avm_address, avm_writedata, p0_rdata and p1_rdata to 0.
REQ-041 An interrupted transaction is not replayed after reset.
REQ-042 Reset release is synchronised by the instantiating level; the first arbitration occurs on the first edge after release.

Verification
REQ-043 Scenario: p0 write to 0x0000100 with data 0xBEEF, waitrequest held high 2 cycles -> avm_write is high for 3 cycles with stable address and data, then p0_done pulses once.
REQ-044 Scenario: p1 read of 0x1FFFFFE, slave returns 0x1234 with readdatavalid 2 cycles after accept -> p1_rdata = 0x1234 with p1_done at cycle 5, and p0_done stays 0.
REQ-045 Scenario: p0 and p1 both held high continuously for writes -> grant order is p0 four times, then p1 once, repeating, and starve_cnt never exceeds 4.
REQ-046 Scenario: reset asserted while in WAIT_RD, then a stray readdatavalid after release -> outputs are 0, the FSM is in IDLE, and no done pulses.
REQ-047 Scenario: simultaneous requests arriving in the same cycle with starve_cnt=0 -> p0 is granted first, and p1 is granted on the next IDLE.
REQ-048 Scenario: p0 req dropped one cycle after grant -> the transaction still completes, and p0_done pulses once.
